alu_iter_exec: RTL and testbench

- Execute-stage ALU of the RISC-V core.
- Sits directly downstream of the ALU controller and consumes its 4-bit Operation code together with the two operand buses from the ID/EX register.
- Logic and arithmetic ops complete in one registered cycle. Shifts are executed iteratively to save area.
- Asserts busy so the hazard unit can stall IF/ID/EX while a shift is in flight.

---
 rtl/alu_iter_exec.sv | 153 +++++++++++++++
 tb/tb_alu_iter_exec.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative SLL/SRL/SRA.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a 1-cycle barrel shifter.
module alu_iter_exec #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic              busy,
    output logic              dbg_state
);
    // Handshake: an op is taken on a rising edge where in_valid && in_ready && !flush;
    // upstream holds its op until then. out_valid is a one-cycle pulse with no backpressure.
    localparam int SW = $clog2(DATA_W);

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_LUI = 4'b0010,
                           OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                           OP_BLT = 4'b0110, OP_BGE = 4'b0111, OP_BEQ = 4'b1000,
                           OP_BNE = 4'b1001, OP_SUB = 4'b1010, OP_ADD = 4'b1011,
                           OP_SLT = 4'b1100, OP_SRA = 4'b1101, OP_JAL = 4'b1110;

    localparam logic [1:0] K_SLL = 2'd0, K_SRL = 2'd1, K_SRA = 2'd2;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            state;
    logic [DATA_W-1:0] work;
    logic [SW-1:0]     rem;
    logic [1:0]        kind;

    logic [SW-1:0]     shamt;
    logic              is_shift;
    logic              accept;
    logic              lt_s;
    logic              shift_start;
    logic [1:0]        kind_c;
    logic [DATA_W-1:0] res_c;
    logic              last_step;
    logic [SW-1:0]     step_amt;
    logic [DATA_W-1:0] work_nxt;

    assign shamt     = SrcB[SW-1:0];
    assign is_shift  = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
    assign accept    = in_valid && in_ready && !flush;
    assign lt_s      = $signed(SrcA) < $signed(SrcB);
    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign dbg_state = (state == SHIFT);

`ifdef ALU_FAST_SHIFT_EN
    assign shift_start = 1'b0;
`else
    assign shift_start = is_shift && (shamt != '0);
`endif

    always_comb begin
        kind_c = K_SLL;
        if (Operation == OP_SRL) kind_c = K_SRL;
        else if (Operation == OP_SRA) kind_c = K_SRA;
    end

    always_comb begin
        res_c = '0;
        case (Operation)
            OP_AND:         res_c = SrcA & SrcB;
            OP_OR:          res_c = SrcA | SrcB;
            OP_LUI:         res_c = SrcB;
            OP_XOR:         res_c = SrcA ^ SrcB;
            OP_ADD:         res_c = SrcA + SrcB;
            OP_SUB:         res_c = SrcA - SrcB;
            OP_SLT, OP_BLT: res_c = DATA_W'(lt_s);
            OP_BGE:         res_c = DATA_W'(!lt_s);
            OP_BEQ:         res_c = DATA_W'(SrcA == SrcB);
            OP_BNE:         res_c = DATA_W'(SrcA != SrcB);
            OP_JAL:         res_c = DATA_W'(1);
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:         res_c = SrcA << shamt;
            OP_SRL:         res_c = SrcA >> shamt;
            OP_SRA:         res_c = $unsigned($signed(SrcA) >>> shamt);
`else
            // Only a zero-amount shift completes here; non-zero amounts iterate.
            OP_SLL, OP_SRL, OP_SRA: res_c = SrcA;
`endif
            default:        res_c = '0;
        endcase
    end

    // The final iteration may move fewer than SHIFT_STEP bits.
    always_comb begin
        last_step = int'(rem) <= SHIFT_STEP;
        step_amt  = last_step ? rem : SW'(SHIFT_STEP);
        case (kind)
            K_SRL:   work_nxt = work >> step_amt;
            K_SRA:   work_nxt = $unsigned($signed(work) >>> step_amt);
            default: work_nxt = work << step_amt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            work      <= '0;
            rem       <= '0;
            kind      <= K_SLL;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (shift_start) begin
                            state <= SHIFT;
                            work  <= SrcA;
                            rem   <= shamt;
                            kind  <= kind_c;
                        end else begin
                            ALUResult <= res_c;
                            Zero      <= (res_c == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else begin
                        work <= work_nxt;
                        rem  <= rem - step_amt;
                        if (last_step) begin
                            state     <= IDLE;
                            ALUResult <= work_nxt;
                            Zero      <= (work_nxt == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: vector table, hand sequences and random ops vs. a reference model.
// Follows ALU_FAST_SHIFT_EN when defined so expectations match the built variant.
module tb_alu_iter_exec;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        flush;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;

    logic        in_ready, out_valid, Zero, busy, dbg_state;
    logic [31:0] ALUResult;
    logic        r4_ready, v4_valid, z4_zero, b4_busy, d4_state;
    logic [31:0] res4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_iter_exec #(.DATA_W(32), .SHIFT_STEP(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .ALUResult(ALUResult), .Zero(Zero), .busy(busy),
        .dbg_state(dbg_state)
    );

    alu_iter_exec #(.DATA_W(32), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r4_ready),
        .flush(flush), .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(v4_valid), .ALUResult(res4), .Zero(z4_zero), .busy(b4_busy),
        .dbg_state(d4_state)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
        int sa, sb, s;
        sa = a;
        sb = b;
        s  = int'(b % 32);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return b;
            4'b0011: return a ^ b;
            4'b1011: return a + b;
            4'b1010: return a - b;
            4'b1100, 4'b0110: return (sa < sb) ? 32'd1 : 32'd0;
            4'b0111: return (sa >= sb) ? 32'd1 : 32'd0;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return (a != b) ? 32'd1 : 32'd0;
            4'b1110: return 32'd1;
            4'b0100: return a << s;
            4'b0101: return a >> s;
            4'b1101: return sa >>> s;
            default: return 32'd0;
        endcase
    endfunction

    // Extra cycles beyond a single-cycle op before the result appears.
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b, input int step);
        int s;
        s = int'(b % 32);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        if (!(op == 4'b0100 || op == 4'b0101 || op == 4'b1101) || s == 0) return 0;
        return (s + step - 1) / step;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op on u_dut (idle, at a negedge) and check latency, busy window and result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, exp, input string nm);
        int lat, cyc, busy_cnt;
        lat = ref_lat(op, b, 1);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!out_valid && cyc < 100) begin
            if (busy && !in_ready) busy_cnt++;
            // Stray requests while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " busy_cycles"}, busy_cnt, lat);
        chk({nm, " result"}, ALUResult, exp);
        chk({nm, " zero"}, Zero, (exp == 32'd0));
        last_res = exp;
        @(negedge clk);
        chk({nm, " pulse_end"}, out_valid, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!in_ready || !r4_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", (in_ready && r4_ready), 1'b1);
    endtask

    vec_t vecs[$];

    initial begin
        int cyc, busy_cnt, lat;
        logic [3:0] op;
        logic [31:0] a, b;

        vecs = '{
            '{4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F},
            '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
            '{4'b0010, 32'h0000_1234, 32'hABCD_E000, 32'hABCD_E000},
            '{4'b0011, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00},
            '{4'b1011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
            '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
            '{4'b1010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
            '{4'b1010, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
            '{4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
            '{4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001},
            '{4'b1001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000},
            '{4'b0110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001},
            '{4'b0111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001},
            '{4'b0111, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
            '{4'b1110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001},
            '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{4'b0101, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678},
            '{4'b1101, 32'h8000_0010, 32'h0000_0003, 32'hF000_0002},
            '{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
            '{4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
            '{4'b1101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF}
        };

        // Reset
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        Operation = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst result", ALUResult, 32'd0);
        chk("rst zero", Zero, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);

        // Back-to-back single-cycle ops
        Operation = 4'b1011; SrcA = 32'h7FFF_FFFF; SrcB = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b add valid", out_valid, 1'b1);
        chk("b2b add result", ALUResult, 32'h8000_0000);
        Operation = 4'b1010; SrcA = 32'd5; SrcB = 32'd5;
        @(negedge clk);
        chk("b2b sub valid", out_valid, 1'b1);
        chk("b2b sub result", ALUResult, 32'd0);
        chk("b2b sub zero", Zero, 1'b1);
        Operation = 4'b0110; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b blt valid", out_valid, 1'b1);
        chk("b2b blt result", ALUResult, 32'd1);
        chk("b2b blt zero", Zero, 1'b0);
        @(negedge clk);
        chk("b2b idle valid", out_valid, 1'b0);

        // Vector table
        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // SHIFT_STEP=4 instance: SLL 1 by 31
        wait_idle();
        lat = ref_lat(4'b0100, 32'd31, 4);
        Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (!v4_valid && cyc < 100) begin
            if (b4_busy && !r4_ready) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk("step4 latency", cyc, lat);
        chk("step4 busy_cycles", busy_cnt, lat);
        chk("step4 result", res4, 32'h8000_0000);
        wait_idle();

        // Flush in IDLE: nothing accepted
        do_op(4'b0011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "pre_flush");
        Operation = 4'b1011; SrcA = 32'd9; SrcB = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush valid", out_valid, 1'b0);
        chk("idle_flush result", ALUResult, last_res);

`ifndef ALU_FAST_SHIFT_EN
        // Flush two cycles into a long SRL
        wait_idle();
        Operation = 4'b0101; SrcA = 32'hFFFF_FFFF; SrcB = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush mid busy", busy, 1'b1);
        chk("flush mid valid", out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush valid", out_valid, 1'b0);
        chk("flush in_ready", in_ready, 1'b1);
        chk("flush result", ALUResult, last_res);
        chk("flush zero", Zero, 1'b0);
        @(negedge clk);
        chk("flush no late valid", out_valid, 1'b0);
        do_op(4'b1011, 32'd2, 32'd3, 32'd5, "post_flush add");

        // Reset mid-shift
        Operation = 4'b1101; SrcA = 32'h8000_0000; SrcB = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst result", ALUResult, 32'd0);
        chk("midrst zero", Zero, 1'b1);
        chk("midrst in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", out_valid, 1'b0);
`else
        do_op(4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, "fast sra");
`endif

        // Random ops vs. reference model
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if (op == 4'b0100 || op == 4'b0101 || op == 4'b1101)
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            else
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(op, a, b, ref_alu(op, a, b), $sformatf("rnd%0d op%b", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
